pipe_mux: RTL

PIPE_MUX -- requirements
Module: pipe_mux

---
 rtl/pipe_mux.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_mux.sv
// One-deep registered channel mux with a valid/ready handshake on both sides.
// Optional illegal-select counter port err_cnt is enabled by defining PIPE_MUX_ERR_CNT_EN.
module pipe_mux #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     NUM_IN    = 3,
  parameter int unsigned     SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h00400030)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef PIPE_MUX_ERR_CNT_EN
  output logic [7:0]              err_cnt,
`endif
  output logic                    sel_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] chan;
  logic             legal;
  logic             xfer_in;
  logic             xfer_out;

  // The output register can take a new word when empty or when it drains this cycle.
  assign in_ready = (state_q == EMPTY) || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = (state_q == FULL) && out_ready;

  // Illegal selects fall back to channel 0.
  always_comb begin
    legal = (32'(sel) < NUM_IN);
    chan  = in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        chan = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    sel_err_d  = sel_err_q;
    case (state_q)
      EMPTY: if (xfer_in) state_d = FULL;
      FULL:  if (xfer_out && !xfer_in) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer_in) begin
      out_data_d = chan;
      if (!legal) sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= RESET_VAL;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (state_q == FULL);
  assign sel_err   = sel_err_q;

`ifdef PIPE_MUX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted illegal selects.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xfer_in && !legal && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
